// File: rtl/combo_lock_seq.sv
// Multi-step combination lock with scrambled inputs, key store,
// failed-attempt counter and timed lockout.
module combo_lock_seq #(
    parameter int N_CH           = 3,
    parameter int N_STEPS        = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    input  logic                          lock,
    input  logic                          enter,
    input  logic [N_CH-1:0]               code_in,
    input  logic                          key_we,
    input  logic [$clog2(N_STEPS)-1:0]    key_addr,
    input  logic [N_CH-1:0]               key_wdata,
    input  logic                          pol_load,
    input  logic [N_CH-1:0]               pol_wdata,
    input  logic                          pol_free,
    output logic                          unlocked,
    output logic                          active,
    output logic                          lockout,
    output logic [$clog2(N_STEPS)-1:0]    step,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int SW = $clog2(N_STEPS);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [SW-1:0]   r_step;
    logic [SW-1:0]   w_step_nx;
    logic [FW-1:0]   r_fail;
    logic [FW-1:0]   w_fail_nx;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nx;
    logic [N_CH-1:0] r_pol;
    logic [N_CH-1:0] r_key [N_STEPS];
    logic [N_CH-1:0] w_eff;
    logic            w_hit;
    logic            w_key_ok;

    // Effective code uses the mask as it stands in the enter cycle.
    assign w_eff = code_in ^ r_pol;
    assign w_hit = (w_eff == r_key[r_step]);

    // Keys are only writable while no entry attempt is in progress.
    assign w_key_ok = key_we
                    && (r_state == S_IDLE || r_state == S_UNLOCKED)
                    && (int'(key_addr) < N_STEPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pol <= '0;
        end else if (pol_load) begin
            r_pol <= pol_wdata;
        end else if (pol_free) begin
            r_pol <= ~r_pol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STEPS; i++) begin
                r_key[i] <= '0;
            end
        end else if (w_key_ok) begin
            r_key[key_addr] <= key_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_fail  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
            r_fail  <= w_fail_nx;
            r_timer <= w_timer_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_fail_nx  = r_fail;
        w_timer_nx = r_timer;
        unique case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nx = S_ARMED;
                    w_step_nx  = '0;
                end
            end
            S_ARMED: begin
                if (lock) begin
                    w_state_nx = S_IDLE;
                    w_step_nx  = '0;
                    w_fail_nx  = '0;
                end else if (arm) begin
                    w_step_nx = '0;
                end else if (enter) begin
                    if (w_hit && r_step == LAST_STEP) begin
                        w_state_nx = S_UNLOCKED;
                        w_step_nx  = '0;
                        w_fail_nx  = '0;
                    end else if (w_hit) begin
                        w_step_nx = r_step + SW'(1);
                    end else begin
                        w_step_nx = '0;
                        if (int'(r_fail) + 1 >= MAX_FAIL) begin
                            w_state_nx = S_LOCKOUT;
                            w_fail_nx  = FW'(MAX_FAIL);
                            w_timer_nx = TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            w_fail_nx = r_fail + FW'(1);
                        end
                    end
                end
            end
            S_UNLOCKED: begin
                if (lock) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nx = S_IDLE;
                    w_fail_nx  = '0;
                end else begin
                    w_timer_nx = r_timer - TW'(1);
                end
            end
        endcase
    end

    assign unlocked = (r_state == S_UNLOCKED);
    assign active   = (r_state == S_ARMED) || (r_state == S_UNLOCKED);
    assign lockout  = (r_state == S_LOCKOUT);
    assign step     = r_step;
    assign fail_cnt = r_fail;

endmodule

// File: tb/tb_combo_lock_seq.sv
// Directed bench for combo_lock_seq with hand-computed expectations.
module tb_combo_lock_seq;

    logic       clk;
    logic       rst_n;
    logic       arm;
    logic       lock;
    logic       enter;
    logic [2:0] code_in;
    logic       key_we;
    logic [1:0] key_addr;
    logic [2:0] key_wdata;
    logic       pol_load;
    logic [2:0] pol_wdata;
    logic       pol_free;
    logic       unlocked;
    logic       active;
    logic       lockout;
    logic [1:0] step;
    logic [1:0] fail_cnt;

    int n_tot;
    int n_bad;
    int lo_cnt;

    combo_lock_seq #(
        .N_CH(3), .N_STEPS(4), .MAX_FAIL(3), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .lock(lock),
        .enter(enter), .code_in(code_in), .key_we(key_we),
        .key_addr(key_addr), .key_wdata(key_wdata),
        .pol_load(pol_load), .pol_wdata(pol_wdata),
        .pol_free(pol_free), .unlocked(unlocked), .active(active),
        .lockout(lockout), .step(step), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_lock();
        lock = 1'b1;
        tick();
        lock = 1'b0;
    endtask

    task automatic do_enter(input logic [2:0] c);
        enter   = 1'b1;
        code_in = c;
        tick();
        enter   = 1'b0;
    endtask

    task automatic wr_key(input logic [1:0] a, input logic [2:0] d);
        key_we    = 1'b1;
        key_addr  = a;
        key_wdata = d;
        tick();
        key_we    = 1'b0;
    endtask

    task automatic load_pol(input logic [2:0] m);
        pol_load  = 1'b1;
        pol_wdata = m;
        tick();
        pol_load  = 1'b0;
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        rst_n = 1'b0;
        {arm, lock, enter, key_we, pol_load, pol_free} = '0;
        code_in = '0; key_addr = '0; key_wdata = '0; pol_wdata = '0;
        tick();
        chk("rst_unl", int'(unlocked), 0);
        chk("rst_act", int'(active), 0);
        chk("rst_lo", int'(lockout), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_fail", int'(fail_cnt), 0);
        #3 rst_n = 1'b1;
        tick();

        wr_key(2'd0, 3'b101);
        wr_key(2'd1, 3'b010);
        wr_key(2'd2, 3'b111);
        wr_key(2'd3, 3'b000);

        // Correct sequence
        do_arm();
        chk("arm_act", int'(active), 1);
        chk("arm_step", int'(step), 0);
        do_enter(3'b101);
        chk("ok_s1", int'(step), 1);
        do_enter(3'b010);
        chk("ok_s2", int'(step), 2);
        do_enter(3'b111);
        chk("ok_s3", int'(step), 3);
        chk("ok_unl0", int'(unlocked), 0);
        do_enter(3'b000);
        chk("ok_unl", int'(unlocked), 1);
        chk("ok_act", int'(active), 1);
        chk("ok_fail", int'(fail_cnt), 0);
        chk("ok_step", int'(step), 0);
        do_enter(3'b101);
        chk("unl_enter", int'(step), 0);
        do_lock();
        chk("relock_unl", int'(unlocked), 0);
        chk("relock_act", int'(active), 0);

        // Wrong entry mid-sequence
        do_arm();
        do_enter(3'b101);
        do_enter(3'b011);
        chk("bad_step", int'(step), 0);
        chk("bad_fail", int'(fail_cnt), 1);
        do_enter(3'b101);
        do_enter(3'b010);
        do_enter(3'b111);
        do_enter(3'b000);
        chk("retry_unl", int'(unlocked), 1);
        chk("retry_fail", int'(fail_cnt), 0);
        do_lock();

        // Lockout
        do_arm();
        do_enter(3'b111);
        do_enter(3'b111);
        chk("lo_fail2", int'(fail_cnt), 2);
        chk("lo_pre", int'(lockout), 0);
        do_enter(3'b111);
        chk("lo_on", int'(lockout), 1);
        chk("lo_fail3", int'(fail_cnt), 3);
        chk("lo_act", int'(active), 0);
        lo_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            arm     = i[0];
            enter   = 1'b1;
            code_in = 3'b101;
            tick();
            if (lockout) lo_cnt++;
            else break;
        end
        arm   = 1'b0;
        enter = 1'b0;
        chk("lo_len", lo_cnt, 16);
        chk("lo_end_act", int'(active), 0);
        chk("lo_end_fail", int'(fail_cnt), 0);
        chk("lo_end_lo", int'(lockout), 0);

        // Static polarity mask
        load_pol(3'b110);
        do_arm();
        do_enter(3'b011);
        do_enter(3'b100);
        do_enter(3'b001);
        chk("pol_s3", int'(step), 3);
        do_enter(3'b110);
        chk("pol_unl", int'(unlocked), 1);
        do_lock();
        load_pol(3'b000);

        // Free-running mask: 000 -> 111 on the arm edge
        pol_free = 1'b1;
        do_arm();
        do_enter(3'b101);
        chk("free_odd_step", int'(step), 0);
        chk("free_odd_fail", int'(fail_cnt), 1);
        do_enter(3'b101);
        chk("free_even_step", int'(step), 1);
        pol_free = 1'b0;
        do_lock();
        load_pol(3'b000);

        // Priority: arm beats enter, lock beats enter
        do_arm();
        do_enter(3'b101);
        arm = 1'b1;
        do_enter(3'b010);
        arm = 1'b0;
        chk("arm_prio", int'(step), 0);
        do_enter(3'b101);
        lock = 1'b1;
        do_enter(3'b010);
        lock = 1'b0;
        chk("lock_prio_act", int'(active), 0);
        chk("lock_prio_step", int'(step), 0);

        // Key write ignored while ARMED
        do_arm();
        wr_key(2'd0, 3'b111);
        do_enter(3'b101);
        chk("kwe_armed", int'(step), 1);
        do_lock();

        // Async reset in LOCKOUT clears everything including keys
        do_arm();
        do_enter(3'b111);
        do_enter(3'b111);
        do_enter(3'b111);
        chk("lo2_on", int'(lockout), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lo", int'(lockout), 0);
        chk("arst_fail", int'(fail_cnt), 0);
        chk("arst_act", int'(active), 0);
        #1 rst_n = 1'b1;
        do_arm();
        do_enter(3'b000);
        do_enter(3'b000);
        do_enter(3'b000);
        do_enter(3'b000);
        chk("arst_keys0", int'(unlocked), 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/combo_lock_seq.md
Name: combo_lock_seq

Overview:
- Parametrised multi-step combination lock.
- Sequence: N_STEPS codes, each N_CH bits wide, checked against a writable key store.
- Inputs pass through a polarity-scramble mask, which can be loaded or made to invert every cycle.
- Adds a failed-attempt counter and a timed lockout. Sits between the debounced user inputs and the status output pins of the tile.

Parameters:
- N_CH, 3, code bits per step (1..8)
- N_STEPS, 4, codes in sequence (2..16)
- MAX_FAIL, 3, wrong entries before lockout (1..15)
- LOCKOUT_CYCLES, 16, clk cycles spent in LOCKOUT (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  level-sampled pulse: start or restart entry
- lock  in  1  pulse: relock from UNLOCKED
- enter  in  1  pulse: sample code_in as current step
- code_in  in  N_CH  raw code bits
- key_we  in  1  key store write strobe
- key_addr  in  clog2(N_STEPS)  key step index
- key_wdata  in  N_CH  key value
- pol_load  in  1  load polarity mask
- pol_wdata  in  N_CH  polarity mask value
- pol_free  in  1  1 = mask inverts every cycle
- unlocked  out  1  state==UNLOCKED
- active  out  1  state==ARMED or UNLOCKED
- lockout  out  1  state==LOCKOUT
- step  out  clog2(N_STEPS)  next step expected
- fail_cnt  out  clog2(MAX_FAIL+1)  wrong entries since last IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, step=0, fail_cnt=0, pol_mask=0, all key entries=0, lockout timer=0. All outputs 0.
- Outputs are registered decodes of state/counters; no combinational path from inputs.
- Polarity mask update, evaluated every cycle:
  - pol_load=1 -> pol_mask<=pol_wdata (pol_load has priority).
  - Else if pol_free=1 -> pol_mask<=~pol_mask.
  - Else hold.
- Effective code: eff = code_in ^ pol_mask, using the mask value present in the enter cycle (pre-update).
- Key store writes are honoured only in IDLE or UNLOCKED; they are ignored in ARMED and LOCKOUT. key_addr>=N_STEPS is ignored.
- FSM, with lock > arm > enter priority for simultaneous pulses:
  - IDLE:
    - arm -> ARMED, step<=0.
    - enter ignored.
  - ARMED:
    - arm -> stay ARMED, step<=0, fail_cnt unchanged.
    - enter with eff==key[step] and step<N_STEPS-1 -> step<=step+1.
    - enter with eff==key[step] and step==N_STEPS-1 -> UNLOCKED, step<=0, fail_cnt<=0.
    - enter with mismatch -> step<=0, fail_cnt<=fail_cnt+1.
    - If fail_cnt+1==MAX_FAIL -> LOCKOUT, timer<=LOCKOUT_CYCLES-1.
    - lock in ARMED -> IDLE, step<=0.
  - UNLOCKED:
    - lock -> IDLE.
    - arm, enter ignored.
  - LOCKOUT:
    - All inputs except pol_* ignored.
    - timer decrements each cycle; at timer==0 -> IDLE, fail_cnt<=0.
    - Total cycles with lockout=1 equals LOCKOUT_CYCLES exactly.
- Latency: status outputs reflect an input pulse on the next rising edge (1 cycle).
- Reset asserted mid-sequence or in LOCKOUT: immediate return to reset values; the key store is also cleared.
- Counters never wrap: fail_cnt saturates at MAX_FAIL; step is bounded by the FSM.

Test Plan:
Defaults; key={101,010,111,000}, pol_mask=000, pol_free=0.
- Correct sequence: arm, then enter 101, 010, 111, 000 on successive cycles -> step 0,1,2,3; unlocked=1 and active=1 one cycle after the 4th enter; fail_cnt=0.
- Wrong entry mid-sequence: enter 101, 011 -> step returns to 0, fail_cnt=1; then a full correct sequence -> unlocked=1.
- Lockout: three wrong enters -> lockout=1 for exactly 16 cycles, during which enter/arm have no effect; then IDLE, fail_cnt=0, active=0.
- Polarity: pol_load 110, arm, enter 011,100,001,110 -> unlocked. With pol_free=1 starting at mask 000, entering raw 101 on an odd cycle (mask=111) mismatches.
- Priority/protection: lock+enter in the same ARMED cycle -> IDLE. key_we in ARMED leaves the key unchanged. Set MAX_FAIL=3 and assert rst_n=0 in LOCKOUT -> all outputs 0 asynchronously and keys reset to 0.
